// File: rtl/manchester_tx_pkg.sv
// manchester_tx_pkg: shared types and helpers for the Manchester transmit scheduler
//   state_t    - scheduler FSM states
//   CHIPS      - chips per encoded byte
//   man_encode - byte to 16-chip word, chip 15 is the high chip of the MSB
package manchester_tx_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    localparam int CHIPS = 16;

    function automatic logic [15:0] man_encode(input logic [7:0] b);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) r[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

endpackage

// File: rtl/manchester_chip_timer.sv
// manchester_chip_timer: chip-period divider producing one tick per div+1 cycles
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - hold the divider at zero
//   div        - period minus one
//   tick       - high in the last cycle of each chip period
module manchester_chip_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = cnt == div;

    // wrapping on the tick rather than on overflow keeps div = all-ones a full period
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;

endmodule

// File: rtl/manchester_tx_sched.sv
// manchester_tx_sched: round-robin byte arbiter, sync framing and Manchester chip serializer
//   req0_*/req1_* - byte requesters, ready is combinational and only asserted in IDLE
//   div_i         - chip period minus one, captured at accept
//   line_o        - registered chip stream, line_en_o high during sync/data chips
//   busy_o        - not IDLE; grant_o - owner of current/last frame
//   frame_done_o  - one-cycle pulse in the first gap cycle
module manchester_tx_sched
    import manchester_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hD5,
    parameter int         GAP_CHIPS = 4,
    parameter int         DIV_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    input  logic [DIV_W-1:0] div_i,
    output logic             line_o,
    output logic             line_en_o,
    output logic             busy_o,
    output logic             grant_o,
    output logic             frame_done_o
);

    localparam logic [3:0] LAST_CHIP = 4'(CHIPS - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CHIPS - 1);

    state_t           state, state_d;
    logic [3:0]       chip;
    logic [15:0]      shreg;
    logic [7:0]       data_q;
    logic [DIV_W-1:0] div_q;
    logic             last_grant, win, idle, acc, tick, last;

    // readys are held low while reset is asserted even though state already reads IDLE
    assign idle       = rst_n && state == IDLE;
    assign win        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = idle && req0_valid && !win;
    assign req1_ready = idle && req1_valid && win;
    assign acc        = req0_ready || req1_ready;
    assign last       = chip == LAST_CHIP;
    assign busy_o     = state != IDLE;
    assign line_o     = shreg[15];

    manchester_chip_timer #(.DIV_W(DIV_W)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == IDLE),
        .div  (div_q),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (acc) state_d = SYNC;
            SYNC:    if (tick && last) state_d = DATA;
            DATA:    if (tick && last) state_d = GAP;
            GAP:     if (tick && chip == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // the shift register drives the line directly; it drains to zero by the end of DATA
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            chip         <= '0;
            shreg        <= '0;
            data_q       <= '0;
            div_q        <= '0;
            grant_o      <= 1'b0;
            last_grant   <= 1'b1;
            line_en_o    <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= state == DATA && tick && last;
            if (acc) begin
                data_q     <= win ? req1_data : req0_data;
                div_q      <= div_i;
                grant_o    <= win;
                last_grant <= win;
                shreg      <= man_encode(SYNC_BYTE);
                chip       <= '0;
                line_en_o  <= 1'b1;
            end else if (tick && state != IDLE) begin
                chip      <= (state != GAP && last) ? 4'd0 : chip + 4'd1;
                shreg     <= (state == SYNC && last) ? man_encode(data_q) : shreg << 1;
                line_en_o <= (state == DATA && last) ? 1'b0 : line_en_o;
            end
        end

endmodule

// File: tb/tb_manchester_tx_sched.sv
// tb_manchester_tx_sched: randomized self-checking bench against a frame-level reference model
module tb_manchester_tx_sched;

    logic       clk, rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data, div_i;
    logic       line_o, line_en_o, busy_o, grant_o, frame_done_o;

    int passed = 0;
    int total  = 0;
    bit exp_last = 1'b1;

    manchester_tx_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .div_i       (div_i),
        .line_o      (line_o),
        .line_en_o   (line_en_o),
        .busy_o      (busy_o),
        .grant_o     (grant_o),
        .frame_done_o(frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected 32-chip frame: sync byte then data, MSB first, 1 -> 10, 0 -> 01
    function automatic logic [31:0] model_chips(input logic [7:0] b);
        logic [15:0] bits;
        logic [31:0] w;
        bits = {8'hD5, b};
        w = '0;
        for (int i = 15; i >= 0; i--) w = {w[29:0], bits[i] ? 2'b10 : 2'b01};
        return w;
    endfunction

    function automatic bit model_winner(input bit v0, input bit v1, input bit lg);
        return (v0 && v1) ? !lg : v1;
    endfunction

    // returns at T+1 (+1 after the accept edge); who = -1 on timeout
    task automatic wait_accept(output int who, output int waited);
        who = -1;
        waited = 0;
        while (waited < 300) begin
            #1;
            if (req0_valid && req0_ready) begin who = 0; break; end
            if (req1_valid && req1_ready) begin who = 1; break; end
            @(posedge clk);
            waited++;
        end
        if (who >= 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    // observes one frame starting at T+1; cycle index c means cycle T+c
    task automatic capture(input int d, output logic [31:0] chips, output int done_at,
                           output int done_n, output int bad, output int idle_at);
        int per, k;
        per = d + 1;
        chips = '0;
        done_at = -1;
        done_n = 0;
        bad = 0;
        idle_at = -1;
        for (int c = 1; c <= 40 * per + 20; c++) begin
            div_i = 8'($urandom);
            if (!busy_o) begin idle_at = c; break; end
            if (frame_done_o) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (req0_ready || req1_ready) bad++;
            if (c <= 32 * per) begin
                k = (c - 1) / per;
                if ((c - 1) % per == 0) chips[31-k] = line_o;
                else if (line_o !== chips[31-k]) bad++;
                if (line_en_o !== 1'b1) bad++;
            end else if (line_o !== 1'b0 || line_en_o !== 1'b0) bad++;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = 8'h00;
        req1_data = 8'h00;
        div_i = 8'h00;
        #3;
        total++;
        if ({line_o, line_en_o, busy_o, grant_o, frame_done_o} !== 5'b0)
            $display("FAIL reset_outputs got %b exp 00000", {line_o, line_en_o, busy_o, grant_o, frame_done_o});
        else passed++;
        total++;
        if ({req0_ready, req1_ready} !== 2'b00)
            $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready});
        else passed++;
        step();
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_div0();
        int who, w, dn_at, dn_n, bad, idl;
        logic [31:0] ch;
        req0_valid = 1'b1;
        req0_data = 8'hA5;
        div_i = 8'd0;
        wait_accept(who, w);
        req0_valid = 1'b0;
        exp_last = model_winner(1'b1, 1'b0, exp_last);
        total++;
        if (who !== int'(exp_last)) $display("FAIL single_who got %0d exp %0d", who, exp_last);
        else passed++;
        total++;
        if (grant_o !== exp_last) $display("FAIL single_grant got %b exp %b", grant_o, exp_last);
        else passed++;
        capture(0, ch, dn_at, dn_n, bad, idl);
        total++;
        if (ch !== model_chips(8'hA5)) $display("FAIL single_chips got %h exp %h", ch, model_chips(8'hA5));
        else passed++;
        total++;
        if (dn_at !== 33 || dn_n !== 1) $display("FAIL single_done got at %0d n %0d exp at 33 n 1", dn_at, dn_n);
        else passed++;
        total++;
        if (idl !== 37) $display("FAIL single_idle got %0d exp 37", idl);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL single_hold got %0d bad cycles exp 0", bad);
        else passed++;
    endtask

    task automatic test_div3();
        int who, w, dn_at, dn_n, bad, idl;
        logic [31:0] ch;
        req1_valid = 1'b1;
        req1_data = 8'h3C;
        div_i = 8'd3;
        wait_accept(who, w);
        req1_valid = 1'b0;
        exp_last = model_winner(1'b0, 1'b1, exp_last);
        total++;
        if (who !== int'(exp_last)) $display("FAIL div3_who got %0d exp %0d", who, exp_last);
        else passed++;
        capture(3, ch, dn_at, dn_n, bad, idl);
        total++;
        if (ch !== model_chips(8'h3C)) $display("FAIL div3_chips got %h exp %h", ch, model_chips(8'h3C));
        else passed++;
        total++;
        if (dn_at !== 129 || dn_n !== 1) $display("FAIL div3_done got at %0d n %0d exp at 129 n 1", dn_at, dn_n);
        else passed++;
        total++;
        if (idl !== 1 + 36 * 4 || bad !== 0) $display("FAIL div3_idle got %0d bad %0d exp %0d bad 0", idl, bad, 1 + 36 * 4);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int who, w, dn_at, dn_n, bad, idl, d;
        bit e;
        logic [31:0] ch;
        req0_data = 8'h00;
        req1_data = 8'hFF;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int f = 0; f < 4; f++) begin
            d = $urandom_range(0, 2);
            div_i = 8'(d);
            wait_accept(who, w);
            if (f == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            e = model_winner(1'b1, 1'b1, exp_last);
            exp_last = e;
            total++;
            if (who !== int'(e) || grant_o !== e) $display("FAIL b2b_grant frame %0d got %0d/%b exp %0d", f, who, grant_o, e);
            else passed++;
            if (f > 0) begin
                total++;
                if (w !== 0) $display("FAIL b2b_period frame %0d got %0d extra idle cycles exp 0", f, w);
                else passed++;
            end
            capture(d, ch, dn_at, dn_n, bad, idl);
            total++;
            if (ch !== model_chips(e ? 8'hFF : 8'h00)) $display("FAIL b2b_chips frame %0d got %h exp %h", f, ch, model_chips(e ? 8'hFF : 8'h00));
            else passed++;
            total++;
            if (idl !== 1 + 36 * (d + 1) || dn_n !== 1 || bad !== 0)
                $display("FAIL b2b_timing frame %0d got idle %0d done %0d bad %0d exp idle %0d done 1 bad 0", f, idl, dn_n, bad, 1 + 36 * (d + 1));
            else passed++;
        end
    endtask

    task automatic test_busy_pulse();
        int who, w, dn_at, dn_n, bad, idl;
        logic [31:0] ch;
        req1_valid = 1'b1;
        req1_data = 8'h5A;
        div_i = 8'd1;
        wait_accept(who, w);
        req1_valid = 1'b0;
        exp_last = model_winner(1'b0, 1'b1, exp_last);
        total++;
        if (who !== int'(exp_last)) $display("FAIL busy_who1 got %0d exp %0d", who, exp_last);
        else passed++;
        fork
            capture(1, ch, dn_at, dn_n, bad, idl);
            begin
                repeat (5) @(posedge clk);
                #3;
                req0_valid = 1'b1;
                req0_data = 8'hC3;
                repeat (3) @(posedge clk);
                #3;
                req0_valid = 1'b0;
                repeat (20) @(posedge clk);
                #3;
                req0_valid = 1'b1;
            end
        join
        total++;
        if (ch !== model_chips(8'h5A) || dn_n !== 1) $display("FAIL busy_frame got %h done %0d exp %h done 1", ch, dn_n, model_chips(8'h5A));
        else passed++;
        total++;
        if (bad !== 0 || idl !== 73) $display("FAIL busy_ready got bad %0d idle %0d exp bad 0 idle 73", bad, idl);
        else passed++;
        div_i = 8'd0;
        wait_accept(who, w);
        req0_valid = 1'b0;
        exp_last = model_winner(1'b1, 1'b0, exp_last);
        total++;
        if (who !== int'(exp_last) || w !== 0) $display("FAIL busy_second got who %0d wait %0d exp who %0d wait 0", who, w, exp_last);
        else passed++;
        capture(0, ch, dn_at, dn_n, bad, idl);
        total++;
        if (ch !== model_chips(8'hC3)) $display("FAIL busy_second_chips got %h exp %h", ch, model_chips(8'hC3));
        else passed++;
    endtask

    task automatic test_reset_mid();
        int who, w, dn_at, dn_n, bad, idl, pulses, busy_seen;
        logic [31:0] ch;
        req0_valid = 1'b1;
        req0_data = 8'hFF;
        div_i = 8'd0;
        wait_accept(who, w);
        req0_valid = 1'b0;
        exp_last = model_winner(1'b1, 1'b0, exp_last);
        repeat (20) step();
        total++;
        if ({line_o, line_en_o} !== 2'b11) $display("FAIL midrst_pre got %b exp 11", {line_o, line_en_o});
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({line_o, line_en_o, busy_o} !== 3'b000) $display("FAIL midrst_async got %b exp 000", {line_o, line_en_o, busy_o});
        else passed++;
        step();
        step();
        rst_n = 1'b1;
        exp_last = 1'b1;
        pulses = 0;
        busy_seen = 0;
        repeat (50) begin
            step();
            if (frame_done_o) pulses++;
            if (busy_o) busy_seen++;
        end
        total++;
        if (pulses !== 0 || busy_seen !== 0) $display("FAIL midrst_quiet got done %0d busy %0d exp 0 0", pulses, busy_seen);
        else passed++;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL midrst_arb got %b exp 10", {req0_ready, req1_ready});
        else passed++;
        wait_accept(who, w);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_last = model_winner(1'b1, 1'b1, exp_last);
        capture(0, ch, dn_at, dn_n, bad, idl);
        total++;
        if (who !== 0 || ch !== model_chips(8'hFF)) $display("FAIL midrst_frame got who %0d chips %h exp 0 %h", who, ch, model_chips(8'hFF));
        else passed++;
    endtask

    task automatic test_random();
        int who, w, dn_at, dn_n, bad, idl, d;
        bit v0, v1, e;
        logic [1:0] v;
        logic [7:0] b0, b1;
        logic [31:0] ch;
        for (int n = 0; n < 6; n++) begin
            v = 2'($urandom_range(1, 3));
            v0 = v[0];
            v1 = v[1];
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            d = $urandom_range(0, 3);
            req0_data = b0;
            req1_data = b1;
            req0_valid = v0;
            req1_valid = v1;
            div_i = 8'(d);
            wait_accept(who, w);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            e = model_winner(v0, v1, exp_last);
            exp_last = e;
            total++;
            if (who !== int'(e) || grant_o !== e) $display("FAIL rand_grant %0d got %0d/%b exp %0d", n, who, grant_o, e);
            else passed++;
            capture(d, ch, dn_at, dn_n, bad, idl);
            total++;
            if (ch !== model_chips(e ? b1 : b0)) $display("FAIL rand_chips %0d got %h exp %h", n, ch, model_chips(e ? b1 : b0));
            else passed++;
            total++;
            if (dn_at !== 1 + 32 * (d + 1) || dn_n !== 1 || idl !== 1 + 36 * (d + 1) || bad !== 0)
                $display("FAIL rand_timing %0d got done %0d/%0d idle %0d bad %0d exp %0d/1 %0d 0", n, dn_at, dn_n, idl, bad, 1 + 32 * (d + 1), 1 + 36 * (d + 1));
            else passed++;
        end
    endtask

    task automatic test_div_max();
        int who, w, dn_at, dn_n, bad, idl;
        logic [7:0] b;
        logic [31:0] ch;
        b = 8'($urandom);
        req1_data = b;
        req1_valid = 1'b1;
        div_i = 8'hFF;
        wait_accept(who, w);
        req1_valid = 1'b0;
        exp_last = model_winner(1'b0, 1'b1, exp_last);
        capture(255, ch, dn_at, dn_n, bad, idl);
        total++;
        if (who !== 1 || ch !== model_chips(b)) $display("FAIL divmax_chips got who %0d %h exp 1 %h", who, ch, model_chips(b));
        else passed++;
        total++;
        if (dn_at !== 1 + 32 * 256 || idl !== 1 + 36 * 256 || bad !== 0)
            $display("FAIL divmax_timing got done %0d idle %0d bad %0d exp %0d %0d 0", dn_at, idl, bad, 1 + 32 * 256, 1 + 36 * 256);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_div0();
        test_div3();
        test_back_to_back();
        test_busy_pulse();
        test_reset_mid();
        test_random();
        test_div_max();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
